// File: rtl/rom_rr_arbiter_pkg.sv
// Shared ROM geometry, requester ids and the read-pipeline tag type.
// Pure definitions: no latency and no flow-control behaviour of its own.
package rom_rr_arbiter_pkg;

    localparam int ROM_WIDTH      = 8;
    localparam int ROM_DEPTH      = 1024;
    localparam int ROM_RD_LATENCY = 1;

    typedef enum logic {
        PORT_ID0 = 1'b0,
        PORT_ID1 = 1'b1
    } port_id_e;

    // One in-flight read: whether the slot is live and which port asked for it.
    typedef struct packed {
        logic     vld;
        port_id_e id;
    } rd_tag_t;

endpackage

// File: rtl/rom_rd_pipe.sv
// Tag shift register of RD_LATENCY+1 stages tracking reads in flight to the ROM.
// Advances every clk; it has no stall input. Reset flushes every in-flight read.
module rom_rd_pipe
    import rom_rr_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = ROM_RD_LATENCY
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_in,
    output rd_tag_t cap_tag,
    output rd_tag_t out_tag
);

    rd_tag_t stage [RD_LATENCY+1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i <= RD_LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i <= RD_LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    // cap_tag lines up with rom_dout; out_tag lines up with the captured rdata.
    assign cap_tag = stage[RD_LATENCY-1];
    assign out_tag = stage[RD_LATENCY];

endmodule

// File: rtl/rom_rr_arbiter.sv
// Two-port round-robin arbiter for a synchronous-read ROM. Data returns RD_LATENCY+1 clk after the grant.
// A requester holds req until granted; grants happen only when ce=1, and the read pipe never stalls.
module rom_rr_arbiter
    import rom_rr_arbiter_pkg::*;
#(
    parameter int WIDTH      = ROM_WIDTH,
    parameter int DEPTH      = ROM_DEPTH,
    parameter int RD_LATENCY = ROM_RD_LATENCY,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             req0,
    input  logic             req1,
    input  logic [AW-1:0]    addr0,
    input  logic [AW-1:0]    addr1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic             rom_ren,
    output logic [AW-1:0]    rom_addr,
    input  logic [WIDTH-1:0] rom_dout
);

    port_id_e last_gnt;
    rd_tag_t  tag_in;
    rd_tag_t  cap_tag;
    rd_tag_t  out_tag;

    // On a tie the port that did not win last time goes first.
    always_comb begin
        gnt0     = rst_n & ce & req0 & (~req1 | (last_gnt == PORT_ID1));
        gnt1     = rst_n & ce & req1 & (~req0 | (last_gnt == PORT_ID0));
        rom_ren  = gnt0 | gnt1;
        rom_addr = '0;
        if (gnt1) begin
            rom_addr = addr1;
        end else if (gnt0) begin
            rom_addr = addr0;
        end
        tag_in.vld = rom_ren;
        tag_in.id  = gnt1 ? PORT_ID1 : PORT_ID0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt <= PORT_ID1;
        end else if (gnt0) begin
            last_gnt <= PORT_ID0;
        end else if (gnt1) begin
            last_gnt <= PORT_ID1;
        end
    end

    rom_rd_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .cap_tag (cap_tag),
        .out_tag (out_tag)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if (cap_tag.vld) begin
            if (cap_tag.id == PORT_ID1) begin
                rdata1 <= rom_dout;
            end else begin
                rdata0 <= rom_dout;
            end
        end
    end

    assign rvalid0 = out_tag.vld & (out_tag.id == PORT_ID0);
    assign rvalid1 = out_tag.vld & (out_tag.id == PORT_ID1);

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Directed scenarios plus randomized traffic against a queue-based model of grants and read returns.
module tb_rom_rr_arbiter;
    import rom_rr_arbiter_pkg::*;

    localparam int AW = $clog2(ROM_DEPTH);

    logic          clk = 1'b0;
    logic          rst_n, ce, req0, req1;
    logic [AW-1:0] addr0, addr1, rom_addr;
    logic          gnt0, gnt1, rvalid0, rvalid1, rom_ren;
    logic [7:0]    rdata0, rdata1;
    logic [7:0]    rom_dout = '0;

    rom_rr_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .req0     (req0),
        .req1     (req1),
        .addr0    (addr0),
        .addr1    (addr1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .rom_ren  (rom_ren),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_word(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    always @(posedge clk) begin
        if (rom_ren) rom_dout <= rom_word(rom_addr);
    end

    // Reference model state
    typedef struct {
        int         due;
        int         id;
        logic [7:0] data;
    } rd_t;

    rd_t        pend[$];
    logic [7:0] exp_rdata [2];
    int         last_id;
    int         cyc;
    int         g_last;
    int         g_hist[$];
    int         ren_cnt;
    int         n_vec;
    int         n_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: inputs already driven; compare at negedge, then advance.
    task automatic cycle();
        int            g;
        logic [1:0]    e_rv;
        logic [AW-1:0] e_addr;
        @(negedge clk);
        e_rv = 2'b00;
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].due == cyc) begin
                e_rv[pend[i].id]          = 1'b1;
                exp_rdata[pend[i].id]     = pend[i].data;
                pend.delete(i);
            end
        end
        g = -1;
        if (rst_n && ce) begin
            if (req0 && req1) g = 1 - last_id;
            else if (req0)    g = 0;
            else if (req1)    g = 1;
        end
        e_addr = (g == 0) ? addr0 : (g == 1) ? addr1 : '0;
        chk("gnt0",     32'(gnt0),     32'(g == 0));
        chk("gnt1",     32'(gnt1),     32'(g == 1));
        chk("rom_ren",  32'(rom_ren),  32'(g >= 0));
        chk("rom_addr", 32'(rom_addr), 32'(e_addr));
        chk("rvalid0",  32'(rvalid0),  32'(e_rv[0]));
        chk("rvalid1",  32'(rvalid1),  32'(e_rv[1]));
        chk("rdata0",   32'(rdata0),   32'(exp_rdata[0]));
        chk("rdata1",   32'(rdata1),   32'(exp_rdata[1]));
        if (g >= 0) begin
            last_id = g;
            pend.push_back('{cyc + ROM_RD_LATENCY + 1, g, rom_word(e_addr)});
            g_hist.push_back(g);
            ren_cnt++;
        end
        if (!rst_n) begin
            pend.delete();
            exp_rdata[0] = '0;
            exp_rdata[1] = '0;
            last_id      = 1;
        end
        g_last = g;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        int         p_req [2];
        logic [9:0] p_addr [2];
        n_vec = 0; n_bad = 0; cyc = 0; last_id = 1; g_last = -1; ren_cnt = 0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        rst_n = 1'b0; ce = 1'b1; req0 = 1'b1; req1 = 1'b1; addr0 = '0; addr1 = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset held with both requesting
        repeat (5) cycle();

        // Single read of address 3
        rst_n = 1'b1; req1 = 1'b0; addr0 = 10'h003;
        cycle();
        chk("single_gnt", 32'(g_last), 32'd0);
        idle(3);
        chk("single_data", 32'(rdata0), 32'hA6);

        // Tie: both held
        g_hist.delete();
        req0 = 1'b1; req1 = 1'b1; addr0 = 10'h001; addr1 = 10'h002;
        repeat (6) cycle();
        idle(3);
        chk("tie_count", 32'(g_hist.size()), 32'd6);
        for (int k = 1; k < g_hist.size(); k++) chk("tie_alt", 32'(g_hist[k] != g_hist[k-1]), 32'd1);
        chk("tie_d0", 32'(rdata0), 32'hA4);
        chk("tie_d1", 32'(rdata1), 32'hA7);

        // ce as a 1-in-10 tick, req1 held throughout
        ren_cnt = 0;
        req1 = 1'b1; addr1 = 10'h055;
        for (int k = 0; k < 30; k++) begin
            ce = (k % 10 == 3);
            cycle();
        end
        ce = 1'b1;
        idle(3);
        chk("tick_ren", 32'(ren_cnt), 32'd3);

        // Top address and idle address
        req0 = 1'b1; addr0 = 10'h3FF;
        cycle();
        idle(3);
        chk("top_data", 32'(rdata0), 32'h5A);

        // Reset arriving while port 1's read is in flight
        req1 = 1'b1; addr1 = 10'h010;
        cycle();
        chk("mid_gnt", 32'(g_last), 32'd1);
        rst_n = 1'b0; req1 = 1'b0;
        cycle();
        rst_n = 1'b1; req0 = 1'b1; req1 = 1'b1; addr0 = 10'h020; addr1 = 10'h021;
        cycle();
        chk("post_rst_first", 32'(g_last), 32'd0);
        chk("post_rst_d1", 32'(rdata1), 32'd0);
        idle(3);

        // Randomized traffic
        p_req[0] = 0; p_req[1] = 0;
        for (int k = 0; k < 2000; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (p_req[p] != 0 && g_last == p) p_req[p] = 0;
                if (p_req[p] != 0 && $urandom_range(0, 49) == 0) p_req[p] = 0;
                if (p_req[p] == 0 && $urandom_range(0, 9) < 6) begin
                    p_req[p]  = 1;
                    p_addr[p] = 10'($urandom);
                end
            end
            rst_n = ($urandom_range(0, 99) != 0);
            ce    = ($urandom_range(0, 4) != 0);
            req0  = (p_req[0] != 0);
            req1  = (p_req[1] != 0);
            addr0 = p_addr[0];
            addr1 = p_addr[1];
            cycle();
            chk("rv_excl", 32'(rvalid0 & rvalid1), 32'd0);
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
